// File: rtl/io_pkg.sv
// Shared definitions for the cpu output-port stage: port indices, size defaults
// and the FIFO event layout {port[IO_PORT_W-1:0], data[WIDTH-1:0]}.
package io_pkg;

    localparam int IO_WIDTH  = 8;
    localparam int IO_DEPTH  = 4;
    localparam int IO_PORT_W = 2;

    typedef enum logic [IO_PORT_W-1:0] {
        PORT_D0 = 2'd0,
        PORT_D1 = 2'd1,
        PORT_D2 = 2'd2,
        PORT_D3 = 2'd3
    } io_port_e;

    // Width of one queued event: port index on top, data below.
    function automatic int ev_width(input int data_w);
        return data_w + IO_PORT_W;
    endfunction

endpackage

// File: rtl/io_fifo.sv
// Synchronous FIFO with a registered head output; an entry written into an empty
// FIFO appears at o_data one cycle later, never combinationally.
module io_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [DW-1:0]            i_data,
    output logic [DW-1:0]            o_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [DW-1:0] r_head;

    logic          w_push;
    logic          w_pop;
    logic [AW-1:0] w_rd_next;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CW'(DEPTH));
    assign w_pop     = i_pop && !o_empty;
    // A full FIFO still takes a push when the head leaves on the same edge.
    assign w_push    = i_push && (!o_full || w_pop);
    assign w_rd_next = r_rd_ptr + AW'(1);

    // NOTE: the storage array has no reset; only pointers, count and the head
    // register need a defined value, and that keeps the array as plain RAM.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // NOTE: sequential state is assigned with <= so every register samples the
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_next;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            // The head register tracks whatever will sit at rd_ptr after this edge.
            if (w_pop) begin
                if (r_count > CW'(1)) begin
                    r_head <= r_mem[w_rd_next];
                end else if (w_push) begin
                    r_head <= i_data;
                end
            end else if (o_empty && w_push) begin
                r_head <= i_data;
            end
        end
    end

    assign o_data  = r_head;
    assign o_count = r_count;

endmodule

// File: rtl/io_out_port.sv
// Output-port stage behind the cpu: four port registers plus an event FIFO.
// Define IO_CHANGE_FILTER_EN to suppress events for writes that change nothing.
module io_out_port
    import io_pkg::*;
#(
    parameter int WIDTH = IO_WIDTH,
    parameter int DEPTH = IO_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   we,
    input  logic [IO_PORT_W-1:0]   port_sel,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       d0_s,
    output logic [WIDTH-1:0]       d1_s,
    output logic [WIDTH-1:0]       d2_s,
    output logic [WIDTH-1:0]       d3_s,
    output logic                   ev_valid,
    output logic [IO_PORT_W-1:0]   ev_port,
    output logic [WIDTH-1:0]       ev_data,
    input  logic                   ev_ready,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   overflow
);

    localparam int EW = ev_width(WIDTH);

    logic [WIDTH-1:0] r_port [4];
    logic             r_overflow;

    logic             w_event;
    logic             w_pop;
    logic             w_empty;
    logic [EW-1:0]    w_head;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                r_port[i] <= '0;
            end
        end else if (we) begin
            r_port[port_sel] <= wdata;
        end
    end

`ifdef IO_CHANGE_FILTER_EN
    logic [WIDTH-1:0] w_cur;
    assign w_cur   = r_port[port_sel];
    assign w_event = we && (wdata != w_cur);
`else
    assign w_event = we;
`endif

    assign w_pop = ev_valid && ev_ready;

    // Dropped only when full and the head is not leaving on this same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overflow <= 1'b0;
        end else if (w_event && full && !w_pop) begin
            r_overflow <= 1'b1;
        end
    end

    io_fifo #(
        .DEPTH (DEPTH),
        .DW    (EW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .i_push  (w_event),
        .i_pop   (w_pop),
        .i_data  ({port_sel, wdata}),
        .o_data  (w_head),
        .o_count (count),
        .o_full  (full),
        .o_empty (w_empty)
    );

    assign ev_valid = !w_empty;
    assign ev_port  = w_head[WIDTH +: IO_PORT_W];
    assign ev_data  = w_head[WIDTH-1:0];
    assign overflow = r_overflow;

    assign d0_s = r_port[PORT_D0];
    assign d1_s = r_port[PORT_D1];
    assign d2_s = r_port[PORT_D2];
    assign d3_s = r_port[PORT_D3];

endmodule

// File: tb/tb_io_out_port.sv
// Directed self-checking bench for io_out_port; expectations follow the filter
// macro IO_CHANGE_FILTER_EN when it is defined.
module tb_io_out_port;

    logic       clk = 1'b0;
    logic       reset;
    logic       we;
    logic [1:0] port_sel;
    logic [7:0] wdata;
    logic [7:0] d0_s, d1_s, d2_s, d3_s;
    logic       ev_valid;
    logic [1:0] ev_port;
    logic [7:0] ev_data;
    logic       ev_ready;
    logic [2:0] count;
    logic       full;
    logic       overflow;

    int n_checks = 0;
    int n_fail   = 0;

    logic [9:0] exp_q [$];

    io_out_port dut (
        .clk      (clk),
        .reset    (reset),
        .we       (we),
        .port_sel (port_sel),
        .wdata    (wdata),
        .d0_s     (d0_s),
        .d1_s     (d1_s),
        .d2_s     (d2_s),
        .d3_s     (d3_s),
        .ev_valid (ev_valid),
        .ev_port  (ev_port),
        .ev_data  (ev_data),
        .ev_ready (ev_ready),
        .count    (count),
        .full     (full),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle 1 time unit for sampling and driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [1:0] p, input logic [7:0] d);
        we = 1'b1; port_sel = p; wdata = d;
        step();
        we = 1'b0;
    endtask

    task automatic pop_expect(input string tag, input logic [1:0] p, input logic [7:0] d);
        check({tag, "_valid"}, ev_valid, 1);
        check({tag, "_port"}, ev_port, p);
        check({tag, "_data"}, ev_data, d);
        ev_ready = 1'b1;
        step();
        ev_ready = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_d0"}, d0_s, 0);
        check({tag, "_d1"}, d1_s, 0);
        check({tag, "_d2"}, d2_s, 0);
        check({tag, "_d3"}, d3_s, 0);
        check({tag, "_valid"}, ev_valid, 0);
        check({tag, "_port"}, ev_port, 0);
        check({tag, "_data"}, ev_data, 0);
        check({tag, "_count"}, count, 0);
        check({tag, "_full"}, full, 0);
        check({tag, "_ovf"}, overflow, 0);
    endtask

    initial begin
        reset = 1'b0; we = 1'b0; port_sel = '0; wdata = '0; ev_ready = 1'b0;
        #23;
        check_all_zero("rst");
        reset = 1'b1;
        step();

        // Single write lands one cycle later, head is registered.
        write(2'd2, 8'd5);
        check("wr_d2", d2_s, 5);
        check("wr_count", count, 1);
        pop_expect("wr_ev", 2'd2, 8'd5);
        check("wr_empty_valid", ev_valid, 0);
        check("wr_empty_count", count, 0);

        // Fill with 1..5; the fifth is dropped but still updates d0_s.
        for (int i = 1; i <= 5; i++) begin
            write(2'((i - 1) % 4), 8'(i));
        end
        check("fill_count", count, 4);
        check("fill_full", full, 1);
        check("fill_ovf", overflow, 1);
        check("fill_d0", d0_s, 5);
        check("fill_d1", d1_s, 2);
        check("fill_d2", d2_s, 3);
        check("fill_d3", d3_s, 4);
        check("fill_head", ev_data, 1);

        // Full with pop and push on the same edge: both accepted.
        ev_ready = 1'b1; we = 1'b1; port_sel = 2'd1; wdata = 8'd9;
        step();
        ev_ready = 1'b0; we = 1'b0;
        check("pp_count", count, 4);
        check("pp_full", full, 1);
        pop_expect("dr0", 2'd1, 8'd2);
        pop_expect("dr1", 2'd2, 8'd3);
        pop_expect("dr2", 2'd3, 8'd4);
        pop_expect("dr3", 2'd1, 8'd9);
        check("dr_count", count, 0);
        check("dr_ovf_sticky", overflow, 1);

        // Reset asserted between edges with three events queued.
        write(2'd0, 8'd10);
        write(2'd1, 8'd11);
        write(2'd2, 8'd12);
        check("mid_count", count, 3);
        #2 reset = 1'b0;
        #1 check_all_zero("mid_rst");
        @(negedge clk);
        reset = 1'b1;
        step();
        write(2'd1, 8'd7);
        check("post_valid", ev_valid, 1);
        check("post_count", count, 1);
        check("post_data", ev_data, 7);
        check("post_d1", d1_s, 7);

        // Backpressure: head stays put for 3 cycles, even with a push behind it.
        we = 1'b1; port_sel = 2'd2; wdata = 8'd20;
        for (int c = 0; c < 3; c++) begin
            step();
            we = 1'b0;
            check("bp_port", ev_port, 1);
            check("bp_data", ev_data, 7);
        end
        check("bp_count", count, 2);

        // Pointer wrap: 10 simultaneous push/pop pairs against a queue model.
        exp_q.push_back({2'd1, 8'd7});
        exp_q.push_back({2'd2, 8'd20});
        for (int i = 0; i < 10; i++) begin
            check("wrap_port", ev_port, exp_q[0][9:8]);
            check("wrap_data", ev_data, exp_q[0][7:0]);
            void'(exp_q.pop_front());
            exp_q.push_back({2'(i % 4), 8'(100 + i)});
            ev_ready = 1'b1; we = 1'b1; port_sel = 2'(i % 4); wdata = 8'(100 + i);
            step();
        end
        ev_ready = 1'b0; we = 1'b0;
        check("wrap_count", count, 2);
        while (exp_q.size() > 0) begin
            pop_expect("wrap_dr", exp_q[0][9:8], exp_q[0][7:0]);
            void'(exp_q.pop_front());
        end
        check("wrap_empty", ev_valid, 0);
        check("wrap_ovf", overflow, 0);

        // Same value written twice to port 3.
        write(2'd3, 8'd128);
        write(2'd3, 8'd128);
        check("flt_d3", d3_s, 128);
`ifdef IO_CHANGE_FILTER_EN
        check("flt_count", count, 1);
        pop_expect("flt_ev0", 2'd3, 8'd128);
`else
        check("flt_count", count, 2);
        pop_expect("flt_ev0", 2'd3, 8'd128);
        pop_expect("flt_ev1", 2'd3, 8'd128);
`endif
        check("flt_empty", count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
